// File: rtl/bash_axil_bridge.sv
// rtl/bash_axil_bridge.sv - AXI4-Lite slave to bash-hash native strobe bus bridge.
// Optional BASH_AXIL_START_GUARD_EN: reject prep/start writes while the core is active.
module bash_axil_bridge #(
   parameter int XLEN    = 32,
   parameter int ADDRLEN = 10,
   parameter int AXI_AW  = 12
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [AXI_AW-1:0]   s_awaddr_i,
   input  logic                s_awvalid_i,
   output logic                s_awready_o,
   input  logic [XLEN-1:0]     s_wdata_i,
   input  logic [XLEN/8-1:0]   s_wstrb_i,
   input  logic                s_wvalid_i,
   output logic                s_wready_o,
   output logic [1:0]          s_bresp_o,
   output logic                s_bvalid_o,
   input  logic                s_bready_i,
   input  logic [AXI_AW-1:0]   s_araddr_i,
   input  logic                s_arvalid_i,
   output logic                s_arready_o,
   output logic [XLEN-1:0]     s_rdata_o,
   output logic [1:0]          s_rresp_o,
   output logic                s_rvalid_o,
   input  logic                s_rready_i,
   output logic                en_o,
   output logic [XLEN/8-1:0]   we_o,
   output logic [ADDRLEN-1:0]  addr_o,
   output logic [XLEN-1:0]     wrdata_o,
   input  logic [XLEN-1:0]     rddata_i,
   input  logic                active_i
);
   localparam int SW = XLEN / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_WACC, S_WRESP, S_RACC, S_RCAP, S_RRESP} state_t;

   state_t              state_q;
   logic                started_q;
   logic                wprio_q;
   logic                aw_full_q, w_full_q, ar_full_q;
   logic [AXI_AW-1:0]   awaddr_q, araddr_q;
   logic [XLEN-1:0]     wdata_q;
   logic [SW-1:0]       wstrb_q;
   logic                en_q;
   logic [SW-1:0]       we_q;
   logic [ADDRLEN-1:0]  addr_q;
   logic [XLEN-1:0]     wrdata_q;
   logic                bvalid_q, rvalid_q;
   logic [1:0]          bresp_q, rresp_q;
   logic [XLEN-1:0]     rdata_q;

   logic                aw_hs, w_hs, ar_hs;
   logic                aw_full_n, w_full_n, ar_full_n;
   logic [AXI_AW-1:0]   awaddr_n, araddr_n;
   logic [XLEN-1:0]     wdata_n;
   logic [SW-1:0]       wstrb_n;
   logic                wr_req, rd_req, wr_win, rd_win;
   logic                aw_oor, ar_oor, wr_guard;

   // Readies come only from registered state; started_q keeps them low through reset.
   assign s_awready_o = started_q & (state_q == S_IDLE) & ~aw_full_q;
   assign s_wready_o  = started_q & (state_q == S_IDLE) & ~w_full_q;
   assign s_arready_o = started_q & (state_q == S_IDLE) & ~ar_full_q
                        & ~(aw_full_q & w_full_q & wprio_q);

   assign aw_hs = s_awready_o & s_awvalid_i;
   assign w_hs  = s_wready_o  & s_wvalid_i;
   assign ar_hs = s_arready_o & s_arvalid_i;

   assign aw_full_n = aw_full_q | aw_hs;
   assign w_full_n  = w_full_q  | w_hs;
   assign ar_full_n = ar_full_q | ar_hs;
   assign awaddr_n  = aw_hs ? s_awaddr_i : awaddr_q;
   assign araddr_n  = ar_hs ? s_araddr_i : araddr_q;
   assign wdata_n   = w_hs  ? s_wdata_i  : wdata_q;
   assign wstrb_n   = w_hs  ? s_wstrb_i  : wstrb_q;

   // A read that loses a same-cycle contest waits in the AR slot behind the write.
   assign wr_req = aw_full_n & w_full_n;
   assign rd_req = ar_full_n;
   assign wr_win = wr_req & (~rd_req | wprio_q);
   assign rd_win = rd_req & ~wr_win;

   assign aw_oor = (awaddr_n >> ADDRLEN) != '0;
   assign ar_oor = (araddr_n >> ADDRLEN) != '0;

`ifdef BASH_AXIL_START_GUARD_EN
   assign wr_guard = active_i & ((awaddr_n[9:4] == 6'b110001) | (awaddr_n[9:4] == 6'b110010));
`else
   logic unused_active;
   assign unused_active = active_i;
   assign wr_guard = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         started_q <= 1'b0;
         wprio_q   <= 1'b1;
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         ar_full_q <= 1'b0;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         en_q      <= 1'b0;
         we_q      <= '0;
         addr_q    <= '0;
         wrdata_q  <= '0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         started_q <= 1'b1;
         if (aw_hs) begin
            aw_full_q <= 1'b1;
            awaddr_q  <= s_awaddr_i;
         end
         if (w_hs) begin
            w_full_q <= 1'b1;
            wdata_q  <= s_wdata_i;
            wstrb_q  <= s_wstrb_i;
         end
         if (ar_hs) begin
            ar_full_q <= 1'b1;
            araddr_q  <= s_araddr_i;
         end
         en_q     <= 1'b0;
         we_q     <= '0;
         addr_q   <= '0;
         wrdata_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (wr_win) begin
                  if (rd_req) wprio_q <= 1'b0;
                  if (aw_oor) begin
                     state_q  <= S_WRESP;
                     bvalid_q <= 1'b1;
                     bresp_q  <= RESP_DECERR;
                  end else if (wr_guard) begin
                     state_q  <= S_WRESP;
                     bvalid_q <= 1'b1;
                     bresp_q  <= RESP_SLVERR;
                  end else begin
                     state_q  <= S_WACC;
                     en_q     <= 1'b1;
                     we_q     <= wstrb_n;
                     addr_q   <= awaddr_n[ADDRLEN-1:0];
                     wrdata_q <= wdata_n;
                  end
               end else if (rd_win) begin
                  if (wr_req) wprio_q <= 1'b1;
                  ar_full_q <= 1'b0;
                  if (ar_oor) begin
                     state_q  <= S_RRESP;
                     rvalid_q <= 1'b1;
                     rresp_q  <= RESP_DECERR;
                     rdata_q  <= '0;
                  end else begin
                     state_q <= S_RACC;
                     en_q    <= 1'b1;
                     addr_q  <= araddr_n[ADDRLEN-1:0];
                  end
               end
            end
            S_WACC: begin
               state_q  <= S_WRESP;
               bvalid_q <= 1'b1;
               bresp_q  <= RESP_OKAY;
            end
            S_WRESP: begin
               if (s_bready_i) begin
                  bvalid_q  <= 1'b0;
                  aw_full_q <= 1'b0;
                  w_full_q  <= 1'b0;
                  state_q   <= S_IDLE;
               end
            end
            S_RACC: state_q <= S_RCAP;
            S_RCAP: begin
               rdata_q  <= rddata_i;
               rresp_q  <= RESP_OKAY;
               rvalid_q <= 1'b1;
               state_q  <= S_RRESP;
            end
            S_RRESP: begin
               if (s_rready_i) begin
                  rvalid_q <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign en_o       = en_q;
   assign we_o       = we_q;
   assign addr_o     = addr_q;
   assign wrdata_o   = wrdata_q;
   assign s_bvalid_o = bvalid_q;
   assign s_bresp_o  = bresp_q;
   assign s_rvalid_o = rvalid_q;
   assign s_rresp_o  = rresp_q;
   assign s_rdata_o  = rdata_q;
endmodule

// File: tb/tb_bash_axil_bridge.sv
// tb/tb_bash_axil_bridge.sv - scoreboard testbench for bash_axil_bridge.
module tb_bash_axil_bridge;
   localparam int XLEN = 32, ADDRLEN = 10, AXI_AW = 12;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [AXI_AW-1:0]  s_awaddr_i = '0, s_araddr_i = '0;
   logic               s_awvalid_i = 0, s_wvalid_i = 0, s_arvalid_i = 0;
   logic               s_bready_i = 1, s_rready_i = 1, active_i = 0;
   logic [XLEN-1:0]    s_wdata_i = '0, rddata_i = '0;
   logic [3:0]         s_wstrb_i = '0;
   logic               s_awready_o, s_wready_o, s_arready_o, s_bvalid_o, s_rvalid_o, en_o;
   logic [1:0]         s_bresp_o, s_rresp_o;
   logic [XLEN-1:0]    s_rdata_o, wrdata_o;
   logic [3:0]         we_o;
   logic [ADDRLEN-1:0] addr_o;

   bash_axil_bridge #(.XLEN(XLEN), .ADDRLEN(ADDRLEN), .AXI_AW(AXI_AW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
      .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
      .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
      .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
      .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
      .en_o(en_o), .we_o(we_o), .addr_o(addr_o), .wrdata_o(wrdata_o),
      .rddata_i(rddata_i), .active_i(active_i)
   );

   typedef struct { logic [3:0] we; logic [9:0] addr; logic [31:0] wd; } acc_t;
   typedef struct { logic [31:0] d; logic [1:0] r; } rsp_t;
   acc_t acc_q[$];
   logic [1:0] b_q[$];
   rsp_t r_q[$];
   acc_t e_acc;
   rsp_t e_rsp;

   int n_tests = 0, n_fail = 0;
   int cyc = 0;
   int en_count = 0, last_en_cyc = -1, b_rise_cyc = -1, r_rise_cyc = -1, b_hs_cyc = -1, r_hs_cyc = -1;
   logic bv_prev = 0, rv_prev = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (en_o) begin
            en_count++;
            last_en_cyc = cyc;
            if (acc_q.size() == 0) check("en_unexpected", 1, 0);
            else begin
               e_acc = acc_q.pop_front();
               check("acc_we", we_o, e_acc.we);
               check("acc_addr", addr_o, e_acc.addr);
               check("acc_wrdata", wrdata_o, e_acc.wd);
            end
         end else check("idle_bus", {we_o, addr_o, wrdata_o}, 0);
         if (s_bvalid_o && !bv_prev) b_rise_cyc = cyc;
         if (s_rvalid_o && !rv_prev) r_rise_cyc = cyc;
         bv_prev = s_bvalid_o;
         rv_prev = s_rvalid_o;
         if (s_bvalid_o && s_bready_i) begin
            b_hs_cyc = cyc;
            if (b_q.size() == 0) check("b_unexpected", 1, 0);
            else check("bresp", s_bresp_o, b_q.pop_front());
         end
         if (s_rvalid_o && s_rready_i) begin
            r_hs_cyc = cyc;
            if (r_q.size() == 0) check("r_unexpected", 1, 0);
            else begin
               e_rsp = r_q.pop_front();
               check("rdata", s_rdata_o, e_rsp.d);
               check("rresp", s_rresp_o, e_rsp.r);
            end
         end
      end else begin
         bv_prev = 0;
         rv_prev = 0;
      end
   end

   task automatic push_acc(input logic [3:0] we, input logic [9:0] a, input logic [31:0] d);
      acc_t x;
      x.we = we; x.addr = a; x.wd = d;
      acc_q.push_back(x);
   endtask

   task automatic push_r(input logic [31:0] d, input logic [1:0] r);
      rsp_t x;
      x.d = d; x.r = r;
      r_q.push_back(x);
   endtask

   task automatic xact(input bit do_aw, input bit do_w, input bit do_r,
                       input logic [11:0] awa, input logic [31:0] wd, input logic [3:0] ws,
                       input logic [11:0] ara, output int hs_cyc);
      bit aw_p = do_aw, w_p = do_w, ar_p = do_r;
      int n = 0;
      hs_cyc = -1;
      @(posedge clk); #1;
      s_awaddr_i = awa; s_wdata_i = wd; s_wstrb_i = ws; s_araddr_i = ara;
      s_awvalid_i = aw_p; s_wvalid_i = w_p; s_arvalid_i = ar_p;
      while ((aw_p || w_p || ar_p) && n < 50) begin
         @(negedge clk);
         n++;
         if (aw_p && s_awready_o) begin aw_p = 0; hs_cyc = cyc; end
         if (w_p && s_wready_o) begin w_p = 0; hs_cyc = cyc; end
         if (ar_p && s_arready_o) begin ar_p = 0; hs_cyc = cyc; end
         @(posedge clk); #1;
         s_awvalid_i = aw_p; s_wvalid_i = w_p; s_arvalid_i = ar_p;
      end
      check("xact_timeout", {aw_p, w_p, ar_p}, 0);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((acc_q.size() + b_q.size() + r_q.size()) != 0 && n < 60) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, "_drain"}, acc_q.size() + b_q.size() + r_q.size(), 0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   initial begin
      int hs, en0;
      rst_n = 0;
      repeat (3) @(negedge clk);
      check("rst_readies", {s_awready_o, s_wready_o, s_arready_o}, 0);
      check("rst_valids", {s_bvalid_o, s_rvalid_o, en_o}, 0);
      check("rst_bus", {we_o, addr_o, wrdata_o, s_rdata_o, s_bresp_o, s_rresp_o}, 0);
      @(posedge clk); #1;
      rst_n = 1;

      push_acc(4'hF, 10'h010, 32'hDEADBEEF);
      b_q.push_back(2'b00);
      xact(1, 1, 0, 12'h010, 32'hDEADBEEF, 4'hF, 12'h0, hs);
      drain("t1");
      check("t1_en_lat", last_en_cyc, hs + 1);
      check("t1_b_lat", b_rise_cyc, hs + 2);

      rddata_i = 32'h12345678;
      push_acc(4'h0, 10'h200, 32'h0);
      push_r(32'h12345678, 2'b00);
      xact(0, 0, 1, 12'h0, 32'h0, 4'h0, 12'h200, hs);
      drain("t2");
      check("t2_en_lat", last_en_cyc, hs + 1);
      check("t2_r_lat", r_rise_cyc, hs + 3);

      en0 = en_count;
      xact(1, 0, 0, 12'h040, 32'h0, 4'h0, 12'h0, hs);
      repeat (2) @(posedge clk);
      check("t3_no_early_en", en_count, en0);
      push_acc(4'h3, 10'h040, 32'hA5A50001);
      b_q.push_back(2'b00);
      xact(0, 1, 0, 12'h0, 32'hA5A50001, 4'h3, 12'h0, hs);
      drain("t3");
      check("t3_en_lat", last_en_cyc, hs + 1);
      check("t3_en_once", en_count, en0 + 1);

      do_reset();
      rddata_i = 32'hCAFE0001;
      push_acc(4'hF, 10'h320, 32'h11112222);
      push_acc(4'h0, 10'h330, 32'h0);
      b_q.push_back(2'b00);
      push_r(32'hCAFE0001, 2'b00);
      xact(1, 1, 1, 12'h320, 32'h11112222, 4'hF, 12'h330, hs);
      drain("t4a");
      check("t4a_read_after_b", last_en_cyc > b_hs_cyc, 1);
      push_acc(4'h0, 10'h330, 32'h0);
      push_acc(4'hC, 10'h324, 32'h33334444);
      push_r(32'hCAFE0001, 2'b00);
      b_q.push_back(2'b00);
      xact(1, 1, 1, 12'h324, 32'h33334444, 4'hC, 12'h330, hs);
      drain("t4b");
      check("t4b_write_after_r", last_en_cyc > r_hs_cyc, 1);

      en0 = en_count;
      s_rready_i = 0;
      push_r(32'h0, 2'b11);
      xact(0, 0, 1, 12'h0, 32'h0, 4'h0, 12'h400, hs);
      begin
         int n = 0;
         while (!s_rvalid_o && n < 20) begin @(negedge clk); n++; end
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t5_hold", {s_rvalid_o, s_rdata_o, s_arready_o, s_awready_o, s_wready_o}, {1'b1, 32'h0, 3'b000});
      end
      s_rready_i = 1;
      drain("t5");
      b_q.push_back(2'b11);
      xact(1, 1, 0, 12'hC10, 32'h5555AAAA, 4'hF, 12'h0, hs);
      drain("t5w");
      check("t5_no_en", en_count, en0);

      en0 = en_count;
      active_i = 1;
`ifdef BASH_AXIL_START_GUARD_EN
      b_q.push_back(2'b10);
`else
      push_acc(4'hF, 10'h320, 32'h00000001);
      b_q.push_back(2'b00);
      en0 = en0 + 1;
`endif
      xact(1, 1, 0, 12'h320, 32'h00000001, 4'hF, 12'h0, hs);
      drain("t6a");
      check("t6_guard_en", en_count, en0);
      rddata_i = 32'h0BADF00D;
      push_acc(4'h0, 10'h310, 32'h0);
      push_r(32'h0BADF00D, 2'b00);
      xact(0, 0, 1, 12'h0, 32'h0, 4'h0, 12'h310, hs);
      drain("t6r");
      active_i = 0;
      push_acc(4'hF, 10'h320, 32'h00000002);
      b_q.push_back(2'b00);
      xact(1, 1, 0, 12'h320, 32'h00000002, 4'hF, 12'h0, hs);
      drain("t6b");

      en0 = en_count;
      @(posedge clk); #1;
      s_awaddr_i = 12'h020; s_wdata_i = 32'h77; s_wstrb_i = 4'hF;
      s_awvalid_i = 1; s_wvalid_i = 1;
      @(negedge clk);
      check("t7_ready", {s_awready_o, s_wready_o}, 2'b11);
      @(posedge clk); #1;
      rst_n = 0;
      s_awvalid_i = 0; s_wvalid_i = 0;
      repeat (3) begin
         @(negedge clk);
         check("t7_rst_quiet", {en_o, s_bvalid_o}, 0);
      end
      @(posedge clk); #1;
      rst_n = 1;
      repeat (3) @(negedge clk);
      check("t7_no_en", en_count, en0);
      check("t7_no_b", s_bvalid_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
